chunked_adder: RTL
==================

CHUNKED_ADDER -- requirements
Module: chunked_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per clock cycle; legal only if WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH.
REQ-003 The block SHALL have clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have start, input, 1 bit: request a new addition.
REQ-006 The block SHALL have A, input, WIDTH bits: addend.
REQ-007 The block SHALL have B, input, WIDTH bits: addend.
REQ-008 The block SHALL have Cin, input, 1 bit: carry-in.
REQ-009 The block SHALL have S, output, WIDTH bits: registered sum.
REQ-010 The block SHALL have Cout, output, 1 bit: registered carry-out.
REQ-011 The block SHALL have busy, output, 1 bit: high while a chunked addition is in progress.
REQ-012 The block SHALL have done, output, 1 bit: one-cycle pulse when S/Cout become valid.

Function
REQ-013 The block SHALL implement states IDLE, ADD, DONE; N = WIDTH/CHUNK.
- IDLE -> ADD on start=1.
- ADD -> ADD while the chunk index < N-1.
- ADD -> DONE after chunk N-1.
- DONE -> ADD if start=1, else DONE -> IDLE.
REQ-014 The block SHALL accept start only in IDLE or DONE, latching A, B and Cin into internal registers, loading the carry register with Cin, clearing the chunk index, and clearing S and Cout to 0.
REQ-015 The block SHALL ignore start while in ADD; the latched operands SHALL NOT change and the in-progress result SHALL NOT be disturbed.
REQ-016 On each ADD edge with index i, the block SHALL compute the sum of chunk i of A, chunk i of B and the carry register, where chunk i is bits [i*CHUNK +: CHUNK].
- The low CHUNK bits of that sum SHALL be written to S chunk i.
- The carry out of that sum SHALL be written to the carry register.
- The index SHALL increment by 1.
REQ-017 On the final chunk, the carry out SHALL also be written to Cout.
REQ-018 Latency SHALL be exactly N cycles: with start accepted at edge E0, busy SHALL be 1 for the cycles following E0 through E(N-1), and done SHALL be 1 in exactly the cycle following EN.
REQ-019 busy and done SHALL never both be 1 in the same cycle.
REQ-020 Final {Cout,S} SHALL equal A + B + Cin as computed at full width (WIDTH+1 bits), for all operand values.
REQ-021 S and Cout SHALL hold their final values after done until the next accepted start.
REQ-022 Back-to-back operation SHALL be supported: start=1 in the DONE cycle SHALL begin a new addition with no idle cycle, giving a throughput of one result per N+1 cycles.
REQ-023 With CHUNK=WIDTH, the block SHALL complete in one ADD cycle (N=1).
REQ-024 With CHUNK=1, the block SHALL operate as a bit-serial adder over WIDTH cycles.

Reset
REQ-025 While rst=1, asynchronously and regardless of clk, the block SHALL force state=IDLE, S=0, Cout=0, busy=0, done=0, and clear the carry register, the chunk index and the operand registers.
REQ-026 rst asserted mid-ADD SHALL abort the operation; no done pulse SHALL follow, and the next start after rst deasserts SHALL begin a fresh addition.
REQ-027 start SHALL be ignored while rst=1.

Verification (WIDTH=16, CHUNK=4 unless stated)
REQ-028 Carry ripple: A=16'hFFFF, B=16'h0001, Cin=0 -> done 4 cycles after the accepting edge; S=16'h0000, Cout=1.
REQ-029 Carry-in: A=16'h1234, B=16'h4321, Cin=1 -> S=16'h5556, Cout=0; busy high for exactly 4 cycles, done high for exactly 1 cycle.
REQ-030 Maximum values: A=B=16'hFFFF, Cin=1 -> S=16'hFFFF, Cout=1, followed by start held high in the DONE cycle with A=16'h0000, B=16'h0000, Cin=0 -> second done 5 cycles after the first; S=0, Cout=0.
REQ-031 Start while busy: start A=16'h00FF, B=16'h0001, then pulse start with A=16'h1111 two cycles later -> result S=16'h0100, Cout=0, with only one done pulse.
REQ-032 Reset mid-operation: assert rst for 1 cycle at the second ADD cycle -> S=0, Cout=0, busy=0 immediately, no done pulse; a subsequent addition of 16'h0003+16'h0004 gives S=16'h0007.
REQ-033 Parameter sweep: CHUNK in {1, 4, 16} with 1000 random A, B, Cin each -> {Cout,S} == A+B+Cin, and done exactly 16, 4, 1 cycles respectively after start is accepted.

Source files
------------

// File: rtl/chunked_adder.sv
// Multi-cycle adder that sums two WIDTH-bit operands CHUNK bits per clock,
// rippling the carry through a register between chunks.
module chunked_adder #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             busy,
   output logic             done
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADD  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   int               off_s;
   logic [CHUNK-1:0] chunk_a_s, chunk_b_s;
   logic [CHUNK:0]   chunk_sum_s;

   // Current chunk slice and its sum with the rippled carry
   always_comb begin
      off_s       = int'(idx_q) * CHUNK;
      chunk_a_s   = a_q[off_s +: CHUNK];
      chunk_b_s   = b_q[off_s +: CHUNK];
      chunk_sum_s = {1'b0, chunk_a_s} + {1'b0, chunk_b_s} + {{CHUNK{1'b0}}, carry_q};
   end

   // Next-state logic for the IDLE/ADD/DONE sequencer and datapath
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      s_d     = s_q;
      cout_d  = cout_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            // A new request is only honoured outside ADD; DONE can chain straight into ADD
            if (start) begin
               state_d = ST_ADD;
               a_d     = A;
               b_d     = B;
               carry_d = Cin;
               idx_d   = {IDX_W{1'b0}};
               s_d     = {WIDTH{1'b0}};
               cout_d  = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADD: begin
            s_d[off_s +: CHUNK] = chunk_sum_s[CHUNK-1:0];
            carry_d             = chunk_sum_s[CHUNK];
            idx_d               = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               state_d = ST_DONE;
               cout_d  = chunk_sum_s[CHUNK];
            end else begin
               state_d = ST_ADD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_ADD);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= {IDX_W{1'b0}};
         carry_q <= 1'b0;
         a_q     <= {WIDTH{1'b0}};
         b_q     <= {WIDTH{1'b0}};
         s_q     <= {WIDTH{1'b0}};
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign S    = s_q;
   assign Cout = cout_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule
